// File: rtl/mc_controller_pkg.sv
// mc_controller_pkg: shared MIPS opcode/funct constants, FSM state and control-word types.
// Holds the state encoding (4-bit), opcode/funct codes, alu_op / pc_src / alu_src_b
// encodings and the packed control word the controller drives onto its ports.
package mc_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REX    = 4'd6,
        S_RWB    = 4'd7,
        S_IEX    = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    // Field order matches the controller's port list so the reset gate is one mux.
    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       iord;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal;
        logic       halted;
    } ctrl_t;

    function automatic logic is_rfunct(input logic [5:0] f);
        return f == FN_ADD || f == FN_SUB || f == FN_AND || f == FN_OR || f == FN_SLT;
    endfunction

endpackage

// File: rtl/mc_controller_decode.sv
// mc_controller_decode: combinational opcode/funct decode giving the successor of DECODE.
// Ports:
//   opcode  in  6  instruction opcode field
//   funct   in  6  R-type function field
//   next    out    state to enter after DECODE (meaningful only when illegal=0)
//   illegal out 1  opcode/funct not supported by this configuration
module mc_controller_decode
    import mc_controller_pkg::*;
#(
    parameter bit EN_JUMP = 1'b1,
    parameter bit EN_BNE  = 1'b1
) (
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output state_t     next,
    output logic       illegal
);

    always_comb begin
        next    = S_FETCH;
        illegal = 1'b0;
        case (opcode)
            OP_LW, OP_SW: next = S_MEMADR;
            OP_RTYPE: begin
                next    = is_rfunct(funct) ? S_REX : S_FETCH;
                illegal = !is_rfunct(funct);
            end
            OP_ADDI: next = S_IEX;
            OP_BEQ:  next = S_BRANCH;
            OP_BNE: begin
                next    = EN_BNE ? S_BRANCH : S_FETCH;
                illegal = !EN_BNE;
            end
            OP_J: begin
                next    = EN_JUMP ? S_JUMP : S_FETCH;
                illegal = !EN_JUMP;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control FSM sequencing PC, IR, register file, ALU and memory.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   opcode, funct         IR fields (held stable by the IR from DECODE onward)
//   zero                  ALU zero flag, used in BRANCH
//   mem_ready             memory completes the current access (ignored when MEM_HS=0)
//   pc_write, pc_src      PC load enable and source select
//   iord                  memory address select (PC / ALUOut)
//   ir_write              IR load enable
//   mem_read, mem_write   memory request strobes
//   alu_src_a, alu_src_b  ALU operand selects
//   alu_op                add / sub / per-funct
//   reg_dst, mem_to_reg   register file write address / data selects
//   reg_write             register file write enable
//   illegal               unsupported instruction seen in DECODE
//   halted                FSM parked in HALT
module mc_controller
    import mc_controller_pkg::*;
#(
    parameter bit MEM_HS    = 1'b1,
    parameter bit EN_JUMP   = 1'b1,
    parameter bit EN_BNE    = 1'b1,
    parameter bit TRAP_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal,
    output logic       halted
);

    state_t state, state_n, dec_next;
    ctrl_t  ctrl;
    logic   dec_illegal;
    logic   mem_done;

    mc_controller_decode #(
        .EN_JUMP(EN_JUMP),
        .EN_BNE (EN_BNE)
    ) u_decode (
        .opcode (opcode),
        .funct  (funct),
        .next   (dec_next),
        .illegal(dec_illegal)
    );

    assign mem_done = !MEM_HS || mem_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_n;
    end

    always_comb begin
        ctrl    = '0;
        state_n = state;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_4;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_src    = PC_INC;
                ctrl.ir_write  = mem_done;
                ctrl.pc_write  = mem_done;
                state_n        = mem_done ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded.
                ctrl.alu_src_b = SRCB_IMM2;
                ctrl.illegal   = dec_illegal;
                state_n        = !dec_illegal ? dec_next : TRAP_HALT ? S_HALT : S_FETCH;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                state_n        = opcode == OP_SW ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
                state_n       = mem_done ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                state_n         = S_FETCH;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
                state_n        = mem_done ? S_FETCH : S_MEMWR;
            end
            S_REX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
                state_n        = S_RWB;
            end
            S_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                state_n        = S_FETCH;
            end
            S_IEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                state_n        = S_IWB;
            end
            S_IWB: begin
                ctrl.reg_write = 1'b1;
                state_n        = S_FETCH;
            end
            S_BRANCH: begin
                // IR still holds the branch, so opcode tells BEQ from BNE here.
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_src    = PC_BR;
                ctrl.pc_write  = opcode == OP_BNE ? !zero : zero;
                state_n        = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_src   = PC_JMP;
                ctrl.pc_write = 1'b1;
                state_n       = S_FETCH;
            end
            S_HALT: ctrl.halted = 1'b1;
            default: state_n = S_FETCH;
        endcase
    end

    // Reset silences every strobe immediately, aborting any in-flight memory access.
    assign {pc_write, pc_src, iord, ir_write, mem_read, mem_write, alu_src_a, alu_src_b,
            alu_op, reg_dst, mem_to_reg, reg_write, illegal, halted} = reset ? '0 : ctrl;

endmodule
